pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised successor to the per-field pipeline flip-flops used between stages. It carries one WIDTH-bit stage payload (the packed ID/EX bundle, for example) through a two-entry skid buffer. A valid/ready handshake replaces the stall_current_stage/stall_next_stage pair. It supports full-throughput streaming and a registered backpressure path, and adds flush, occupancy reporting and an optional stall-cycle counter.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on rst

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream stage presents a payload
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  buffer can accept; registered (no combinational path from out_ready)
- out_valid  output  1  payload available to downstream stage
- out_data  output  WIDTH  downstream payload (main register)
- out_ready  input  1  downstream stage accepts this cycle
- flush  input  1  discard all held payloads (branch/exception kill)
- occupancy  output  2  number of held entries, 0..2
- stall_cycles  output  32  downstream backpressure count (see Configuration)

## Operation
- Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = main_valid; out_data = main_data; in_ready = ~skid_valid; occupancy = main_valid + skid_valid.
- States (encoded by the valid bits): EMPTY (0 entries), HALF (main only), FULL (main + skid). skid_valid with main_valid clear never occurs.
- EMPTY: in_fire → main ← in_data, go to HALF; otherwise stay.
- HALF: in_fire & out_fire → main ← in_data, stay in HALF. in_fire only → skid ← in_data, go to FULL. out_fire only → EMPTY. Neither → hold.
- FULL: in_ready = 0. out_fire → main ← skid_data, go to HALF. Otherwise hold.
- Ordering is strict FIFO; the skid entry never overtakes main.
- flush (highest priority below rst): main_valid, skid_valid ← 0 next edge, regardless of in_fire/out_fire that cycle. The payload presented with flush is dropped. Data registers are not cleared. out_fire in the flush cycle still counts as a completed transfer for downstream.
- rst: both valid bits ← 0, both data registers ← RESET_VALUE, stall_cycles ← 0. rst overrides flush and all handshakes, including mid-transfer.
- Data registers load only on the transitions above; held values do not change while stalled.

## Timing
- Latency: in_fire at edge N → out_valid = 1 with that payload after edge N (visible cycle N+1).
- Throughput: 1 payload/cycle sustained while out_ready = 1.
- in_ready falls the cycle after a HALF→FULL transition and rises the cycle after the FULL→HALF transition. The upstream stage sees backpressure one cycle late, and the skid entry absorbs that cycle.
- Reset values: out_valid 0, in_ready 1, occupancy 0, out_data RESET_VALUE, stall_cycles 0.
- After flush: out_valid 0, in_ready 1, occupancy 0 in the next cycle.
- All outputs are registered or derived from register state only. There is no combinational path from an input to an output.

## Configuration
- PIPE_SKID_PERF_EN defined: stall_cycles increments by 1 on every edge where out_valid & ~out_ready and rst is low. It saturates at 32'hFFFF_FFFF and is unaffected by flush.
- PIPE_SKID_PERF_EN undefined: the counter register is not built and stall_cycles is tied to 32'd0.

## Test plan
- Reset then stream: rst for 2 cycles; drive in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 on cycles 1–4 after first fire; in_ready stays 1; occupancy stays 1.
- Backpressure/skid: out_ready=0, push 0xA then 0xB → occupancy 2, in_ready 0. 0xC is held on in_data and not accepted. Raise out_ready → output order 0xA, 0xB, 0xC with no loss or duplication.
- Simultaneous in/out in HALF: main=0x5, in_data=0x6 with in_valid=1, out_ready=1 → next cycle out_data 0x6, occupancy 1.
- Flush in FULL with in_valid=1 (data 0x9) → next cycle occupancy 0, out_valid 0, in_ready 1; 0x9 never appears at the output.
- Reset mid-operation: FULL state, assert rst with flush=1 and out_ready=1 → next cycle out_data = RESET_VALUE, occupancy 0, stall_cycles 0.
- Perf macro: with PIPE_SKID_PERF_EN, hold out_valid=1, out_ready=0 for 7 cycles → stall_cycles = 7. Without the macro → stall_cycles = 0 throughout.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// -----------------------------------------------------------------------------
// Two-entry skid buffer that carries one WIDTH-bit stage payload between
// pipeline stages with a valid/ready handshake. It streams at one payload
// per cycle. in_ready is registered (taken from the skid valid bit), so a
// stalled downstream stage never creates a combinational path back upstream.
// The skid entry absorbs the one payload that arrives in the cycle before
// upstream sees in_ready fall.
//
// Parameters:
//   WIDTH        payload width in bits (>= 1)
//   RESET_VALUE  value loaded into both data registers on rst
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (overrides flush/handshakes)
//   in_valid      upstream presents a payload
//   in_data       upstream payload
//   in_ready      buffer can accept (registered)
//   out_valid     payload available downstream
//   out_data      downstream payload (main register)
//   out_ready     downstream accepts this cycle
//   flush         drop all held payloads, including the one presented now
//   occupancy     number of held entries, 0..2
//   stall_cycles  count of edges with out_valid & ~out_ready
//
// Optional feature macro: PIPE_SKID_PERF_EN
//   defined   -> saturating 32-bit stall-cycle counter is built
//   undefined -> stall_cycles is tied to zero
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [31:0]      stall_cycles
);

  // State encoding doubles as the valid bits: bit 0 = main_valid and
  // bit 1 = skid_valid. The pattern 2'b10 (skid without main) is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_from_in;
  logic             load_main_from_skid;
  logic             load_skid_from_in;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // Next-state and data-load selection. Flush forces EMPTY and suppresses
  // every load, so the payload presented alongside flush is dropped.
  always_comb begin
    state_d             = state_q;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid_from_in   = 1'b0;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_from_in = 1'b1;
          state_d           = HALF;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          load_main_from_in = 1'b1;
        end else if (in_fire) begin
          load_skid_from_in = 1'b1;
          state_d           = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Skid moves up into main so it never overtakes the older entry.
        if (out_fire) begin
          load_main_from_skid = 1'b1;
          state_d             = HALF;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d             = EMPTY;
      load_main_from_in   = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid_from_in   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers. They load only on handshake transitions, so held
  // values stay frozen while the buffer is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= RESET_VALUE;
      skid_data <= RESET_VALUE;
    end else begin
      if (load_main_from_in) begin
        main_data <= in_data;
      end else if (load_main_from_skid) begin
        main_data <= skid_data;
      end
      if (load_skid_from_in) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of downstream backpressure edges. Flush does not
  // affect this count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (main_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
// -----------------------------------------------------------------------------
// Self-checking bench for pipe_skid_reg. A reference model holds the buffer
// contents as a bounded FIFO queue of at most two entries. Directed
// scenarios run first, then a randomized handshake run checks every cycle
// against that model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int unsigned W     = 8;
  localparam logic [W-1:0] RVAL = 8'h5A;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [1:0]   occupancy;
  logic [31:0]  stall_cycles;

  int tests_run;
  int tests_failed;

  // Reference model: FIFO contents plus expected stall counter.
  logic [W-1:0] mq[$];
  logic [31:0]  exp_stall;

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RVAL)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .flush        (flush),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the currently driven inputs, then
  // step the clock and settle 1 time unit past the edge.
  task automatic tick();
    bit in_f;
    bit out_f;
    in_f  = in_valid && (mq.size() < 2);
    out_f = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      exp_stall = 32'd0;
    end else begin
`ifdef PIPE_SKID_PERF_EN
      if ((mq.size() > 0) && !out_ready && (exp_stall != 32'hFFFF_FFFF))
        exp_stall = exp_stall + 32'd1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        if (out_f) void'(mq.pop_front());
        if (in_f) mq.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests_run++;
    if (out_data !== RVAL) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected %h", out_data, RVAL); end
    tests_run++;
    if (stall_cycles !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cycles); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        tests_failed++;
        $display("[TB] FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, W'(i));
      end
      tests_run++;
      if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
        tests_failed++;
        $display("[TB] FAIL stream_occ[%0d]: got rdy=%b occ=%0d expected rdy=1 occ=1", i, in_ready, occupancy);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL stream_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_skid();
    logic [W-1:0] expect_seq[3];
    expect_seq[0] = 8'h0A; expect_seq[1] = 8'h0B; expect_seq[2] = 8'h0C;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A; tick();
    in_data   = 8'h0B; tick();
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL skid_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready);
    end
    in_data = 8'h0C; tick();
    tests_run++;
    if (occupancy !== 2'd2 || out_data !== 8'h0A) begin
      tests_failed++;
      $display("[TB] FAIL skid_hold: got occ=%0d d=%h expected occ=2 d=0a", occupancy, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== expect_seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL skid_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, expect_seq[i]);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL skid_no_dup: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    tick();
    in_data = 8'h06; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data !== 8'h06 || occupancy !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL simul_half: got d=%h occ=%0d expected d=06 occ=1", out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h09; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_full: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_dropped[%0d]: got v=%b d=%h expected v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h03; tick();
    in_data = 8'h04; tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data !== RVAL || occupancy !== 2'd0 || stall_cycles !== 32'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got d=%h occ=%0d stall=%0d v=%b expected d=%h occ=0 stall=0 v=0",
               out_data, occupancy, stall_cycles, out_valid, RVAL);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_perf();
    logic [31:0] want;
`ifdef PIPE_SKID_PERF_EN
    want = 32'd7;
`else
    want = 32'd0;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    tests_run++;
    if (stall_cycles !== want) begin
      tests_failed++;
      $display("[TB] FAIL perf_stall: got %0d expected %0d", stall_cycles, want);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (stall_cycles !== want) begin
      tests_failed++;
      $display("[TB] FAIL perf_hold: got %0d expected %0d", stall_cycles, want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      in_data   = W'($urandom);
      tick();
      tests_run++;
      if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        tests_failed++;
        $display("[TB] FAIL rand_state[%0d]: got occ=%0d v=%b rdy=%b expected occ=%0d", c, occupancy, out_valid, in_ready, mq.size());
      end
      if (mq.size() > 0) begin
        tests_run++;
        if (out_data !== mq[0]) begin
          tests_failed++;
          $display("[TB] FAIL rand_data[%0d]: got %h expected %h", c, out_data, mq[0]);
        end
      end
      tests_run++;
      if (stall_cycles !== exp_stall) begin
        tests_failed++;
        $display("[TB] FAIL rand_stall[%0d]: got %0d expected %0d", c, stall_cycles, exp_stall);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_stall    = 32'd0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
